// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, FSM
// state encoding and default latencies.
package md_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // True for the ops that occupy the unit for a multi-cycle run.
    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for a latched mult/multu/div/divu; wr_c is low
// when the result must not be committed (divide by zero).
module md_arith
    import md_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi_c,
    output logic [DATA_W-1:0] lo_c,
    output logic              wr_c
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   q_u;
    logic [DATA_W-1:0]   r_u;
    logic [DATA_W-1:0]   q_s;
    logic [DATA_W-1:0]   r_s;

    // Signed divide runs on magnitudes; the quotient is then negated when the
    // operand signs differ, the remainder takes the dividend's sign. This also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

        neg_a = (op == OP_DIV) && a[DATA_W-1];
        neg_b = (op == OP_DIV) && b[DATA_W-1];
        mag_a = neg_a ? (DATA_W'(0) - a) : a;
        mag_b = neg_b ? (DATA_W'(0) - b) : b;
        if (mag_b == DATA_W'(0)) begin
            mag_b = DATA_W'(1);
        end

        q_u = mag_a / mag_b;
        r_u = mag_a % mag_b;
        q_s = (neg_a ^ neg_b) ? (DATA_W'(0) - q_u) : q_u;
        r_s = neg_a ? (DATA_W'(0) - r_u) : r_u;

        hi_c = '0;
        lo_c = '0;
        wr_c = 1'b0;
        case (op)
            OP_MULT: begin
                {hi_c, lo_c} = prod_s;
                wr_c         = 1'b1;
            end
            OP_MULTU: begin
                {hi_c, lo_c} = prod_u;
                wr_c         = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                hi_c = r_s;
                lo_c = q_s;
                wr_c = (b != DATA_W'(0));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide responder: owns HI/LO, runs fixed-latency
// mult/div behind a start/busy handshake, and services mthi/mtlo when idle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] md_in1,
    input  logic [DATA_W-1:0] md_in2,
    input  logic [OP_W-1:0]   md_op,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              busy_d;
    logic [DATA_W-1:0] hi_d, lo_d;

    logic [DATA_W-1:0] res_hi_c, res_lo_c;
    logic              res_wr_c;

    md_arith u_arith (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi_c (res_hi_c),
        .lo_c (res_lo_c),
        .wr_c (res_wr_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            busy    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy    <= busy_d;
            hi_out  <= hi_d;
            lo_out  <= lo_d;
        end
    end

    // Counter is loaded with N-1 so busy spans exactly N cycles after start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy;
        hi_d    = hi_out;
        lo_d    = lo_out;

        case (state_q)
            ST_IDLE: begin
                if (start && is_md_op(md_op)) begin
                    op_d    = md_op;
                    a_d     = md_in1;
                    b_d     = md_in2;
                    cnt_d   = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (!start && (md_op == OP_MTHI)) begin
                    hi_d = md_in1;
                end else if (!start && (md_op == OP_MTLO)) begin
                    lo_d = md_in1;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(0)) begin
                    if (res_wr_c) begin
                        hi_d = res_hi_c;
                        lo_d = res_lo_c;
                    end
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_md_unit;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [3:0]  md_op  = 4'd0;
    logic [31:0] md_in1 = 32'd0;
    logic [31:0] md_in2 = 32'd0;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int errors = 0;
    int checks = 0;

    // Model state: outstanding busy cycles and the result computed at launch.
    bit          m_busy;
    int          m_rem;
    logic [31:0] m_hi, m_lo;
    logic [31:0] p_hi, p_lo;
    bit          p_we;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_in1 (md_in1),
        .md_in2 (md_in2),
        .md_op  (md_op),
        .start  (start),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_rem  = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        p_we   = 1'b0;
    endtask

    task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl, output bit we);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = a;
        sb = b;
        we = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                rh = sp[63:32];
                rl = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                rh = up[63:32];
                rl = up[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) we = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = a;
                    rh = 32'd0;
                end else begin
                    rl = 32'(sa / sb);
                    rh = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) we = 1'b0;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endtask

    task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                if (p_we) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (s && op >= OP_MULT && op <= OP_DIVU) begin
            model_result(op, a, b, p_hi, p_lo, p_we);
            m_busy = 1'b1;
            m_rem  = (op <= OP_MULTU) ? MULT_N : DIV_N;
        end else if (!s && op == OP_MTHI) begin
            m_hi = a;
        end else if (!s && op == OP_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic compare();
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("hi", hi_out, m_hi);
        chk("lo", lo_out, m_lo);
    endtask

    // Drive at the falling edge, advance the model on the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = s;
        md_op  = op;
        md_in1 = a;
        md_in2 = b;
        @(posedge clk);
        model_edge(s, op, a, b);
        @(negedge clk);
        compare();
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        int g;
        step(1'b1, op, a, b);
        n = 0;
        g = 0;
        while (busy && g < 64) begin
            n++;
            g++;
            step(1'b0, OP_NONE, 32'd0, 32'd0);
        end
        if (g >= 64) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles", g);
        end
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic reset_between_edges(input string name);
        #2 reset = 1'b1;
        #1;
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_hi"}, hi_out, 32'd0);
        chk({name, "_lo"}, lo_out, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int g;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        reset = 1'b0;

        step(1'b0, OP_MTHI, 32'h0000_ABCD, 32'd0);
        step(1'b0, OP_MTLO, 32'h0000_0055, 32'd0);
        chk("mthi_pre", hi_out, 32'h0000_ABCD);
        reset_between_edges("async_rst");

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi_out, 32'hFFFF_FFFF);
        chk("mult_lo", lo_out, 32'hFFFF_FFFA);

        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi_out, 32'h0000_0002);
        chk("multu_lo", lo_out, 32'hFFFF_FFFA);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_hi", hi_out, 32'hFFFF_FFFF);
        chk("div_lo", lo_out, 32'hFFFF_FFFD);

        run_op(OP_DIVU, 32'd7, 32'd0, n);
        chk("divu0_cycles", 32'(n), 32'd10);
        chk("divu0_hi", hi_out, 32'hFFFF_FFFF);
        chk("divu0_lo", lo_out, 32'hFFFF_FFFD);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_hi", hi_out, 32'h0000_0000);
        chk("div_ovf_lo", lo_out, 32'h8000_0000);

        // Second start at busy cycle 2 must be dropped.
        n = 0;
        step(1'b1, OP_MULT, 32'd5, 32'd7);
        n += int'(busy);
        step(1'b1, OP_DIVU, 32'd100, 32'd3);
        n += int'(busy);
        g = 0;
        while (busy && g < 64) begin
            step(1'b0, OP_NONE, 32'd0, 32'd0);
            n += int'(busy);
            g++;
        end
        chk("start_in_run_cycles", 32'(n), 32'd5);
        chk("start_in_run_hi", hi_out, 32'd0);
        chk("start_in_run_lo", lo_out, 32'd35);

        step(1'b0, OP_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_hi", hi_out, 32'h0000_1234);
        step(1'b1, OP_MULT, 32'h10, 32'h10);
        g = 0;
        while (busy && g < 64) begin
            step(1'b0, OP_MTLO, 32'h0000_DEAD, 32'd0);
            g++;
        end
        chk("mtlo_run_hi", hi_out, 32'd0);
        chk("mtlo_run_lo", lo_out, 32'h0000_0100);

        step(1'b1, OP_MULT, 32'd3, 32'd4);
        step(1'b0, OP_NONE, 32'd0, 32'd0);
        step(1'b0, OP_NONE, 32'd0, 32'd0);
        reset_between_edges("mid_op_rst");
        run_op(OP_MULT, 32'd6, 32'd7, n);
        chk("post_rst_cycles", 32'(n), 32'd5);
        chk("post_rst_hi", hi_out, 32'd0);
        chk("post_rst_lo", lo_out, 32'd42);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), pick_operand(), pick_operand());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
